// File: rtl/rand_range_if.sv
// Handshake bundle between the xorshift generator / requester and rand_range.
// The master side is the requester/consumer; the slave side is rand_range itself.
interface rand_range_if;
  logic [15:0] randnum;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] limit;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] value;
  logic [3:0]  tries;

  modport master (
    output randnum, req_valid, limit, out_ready,
    input  req_ready, out_valid, value, tries
  );

  modport slave (
    input  randnum, req_valid, limit, out_ready,
    output req_ready, out_valid, value, tries
  );
endinterface

// File: rtl/rand_range.sv
// Uniform value in [0, limit) from a free-running 16-bit random word using
// mask-and-reject sampling, with a subtract fallback after MAX_TRIES rejections.
module rand_range #(
  parameter int unsigned MAX_TRIES = 8
) (
  input  logic         clk,
  input  logic         rst,
  rand_range_if.slave  bus
);

  if (MAX_TRIES < 1 || MAX_TRIES > 15) begin : g_bad_max_tries
    $error("rand_range: MAX_TRIES must be in 1..15");
  end

  localparam logic [3:0] MAX_TRIES_L = 4'(MAX_TRIES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] lim_q, lim_d;
  logic [15:0] mask_q, mask_d;
  logic [15:0] value_q, value_d;
  logic [3:0]  tries_q, tries_d;
  logic        out_valid_q, out_valid_d;

  logic [15:0] lim_m1;
  logic [15:0] smear;
  logic [15:0] new_mask;
  logic [15:0] cand;
  logic [15:0] cand_fb;
  logic [3:0]  tries_inc;
  logic        accept;
  logic        last_try;

  // Mask of all ones at and below the MSB of (limit - 1); limit 0 spans all 16 bits.
  always_comb begin
    lim_m1   = bus.limit - 16'd1;
    smear    = lim_m1 | (lim_m1 >> 1);
    smear    = smear | (smear >> 2);
    smear    = smear | (smear >> 4);
    smear    = smear | (smear >> 8);
    new_mask = (bus.limit == 16'd0) ? 16'hFFFF : smear;
  end

  always_comb begin
    cand      = bus.randnum & mask_q;
    cand_fb   = cand - lim_q;
    accept    = (lim_q == 16'd0) || (cand < lim_q);
    tries_inc = (tries_q == 4'hF) ? 4'hF : tries_q + 4'd1;
    last_try  = (tries_inc == MAX_TRIES_L);
  end

  always_comb begin
    state_d     = state_q;
    lim_d       = lim_q;
    mask_d      = mask_q;
    value_d     = value_q;
    tries_d     = tries_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          lim_d   = bus.limit;
          mask_d  = new_mask;
          tries_d = 4'd0;
          state_d = S_SEARCH;
        end
      end

      S_SEARCH: begin
        tries_d = tries_inc;
        if (accept) begin
          value_d     = cand;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else if (last_try) begin
          // cand <= mask <= 2*lim - 1, so cand - lim always lands below lim.
          value_d     = cand_fb;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end

      S_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lim_q       <= 16'd0;
      mask_q      <= 16'd0;
      value_q     <= 16'd0;
      tries_q     <= 4'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lim_q       <= lim_d;
      mask_q      <= mask_d;
      value_q     <= value_d;
      tries_q     <= tries_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.value     = value_q;
  assign bus.tries     = tries_q;

endmodule

// File: tb/tb_rand_range.sv
// Scoreboard bench for rand_range: directed edge cases, backpressure, async
// reset abort, and 1000 requests against a live xorshift16 generator.
module tb_rand_range;

  localparam int MT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rand_range_if bus();

  rand_range #(.MAX_TRIES(MT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] v;
    int          k;
    int          lim;
    int          rdy_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          errors   = 0;
  int          n_issued = 0;
  int          n_done   = 0;
  int          bp_until = 0;
  bit          rnd_ready = 1'b0;
  logic [15:0] xs = 16'hACE1;
  logic [15:0] d[MT];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] xs_step(input logic [15:0] x);
    logic [15:0] y;
    y = x;
    y = y ^ (y << 7);
    y = y ^ (y >> 9);
    y = y ^ (y << 8);
    return y;
  endfunction

  // Reference: sample space is the smallest power of two covering the range,
  // try each supplied word in turn, fall back to subtraction on the last try.
  function automatic void model(input int lim, input logic [15:0] s[MT],
                                output logic [15:0] v, output int k);
    int rng;
    int span;
    int c;
    rng  = (lim == 0) ? 65536 : lim;
    span = 1;
    while (span < rng) span = span * 2;
    v = 16'd0;
    k = MT;
    for (int i = 1; i <= MT; i++) begin
      c = int'(s[i-1]) % span;
      if (c < rng) begin
        v = 16'(c);
        k = i;
        return;
      end
      if (i == MT) begin
        v = 16'(c - rng);
        k = i;
        return;
      end
    end
  endfunction

  task automatic set_seq(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    d[0] = a;
    d[1] = b;
    for (int i = 2; i < MT; i++) d[i] = c;
  endtask

  // Called at posedge+1; returns at posedge+1 once the request is fully fed.
  task automatic do_req(input int lim, input bit directed, input int stall, input int abort_at);
    logic [15:0] s[MT];
    logic [15:0] v;
    logic [15:0] t;
    int          k;
    int          hs;
    int          waitc;
    bus.req_valid = 1'b1;
    bus.limit     = 16'(lim);
    xs            = xs_step(xs);
    bus.randnum   = xs;
    waitc         = 0;
    forever begin
      @(negedge clk);
      if (bus.req_ready) break;
      waitc++;
      if (waitc > 100) begin
        check("req_ready_timeout", 0, 1);
        bus.req_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      xs          = xs_step(xs);
      bus.randnum = xs;
    end
    @(posedge clk);
    #1;
    hs = cyc;
    bus.req_valid = 1'b0;
    if (directed) begin
      s = d;
    end else begin
      t = xs;
      for (int i = 0; i < MT; i++) begin
        t    = xs_step(t);
        s[i] = t;
      end
    end
    if (abort_at > 0) begin
      for (int i = 0; i < abort_at; i++) begin
        if (i > 0) begin
          @(posedge clk);
          #1;
        end
        bus.limit   = 16'($urandom);
        bus.randnum = s[i];
      end
      #2;
      rst = 1'b1;
      #1;
      check("abort_out_valid", int'(bus.out_valid), 0);
      check("abort_req_ready", int'(bus.req_ready), 1);
      check("abort_tries", int'(bus.tries), 0);
      @(negedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    model(lim, s, v, k);
    exp_q.push_back('{v, k, lim, hs + k});
    n_issued++;
    if (stall > 0) bp_until = hs + stall;
    for (int i = 0; i < k; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      bus.limit = 16'($urandom);
      if (directed) begin
        bus.randnum = s[i];
      end else begin
        xs          = xs_step(xs);
        bus.randnum = xs;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Consumer: optional forced stall window, otherwise random or always-ready.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (cyc < bp_until)  bus.out_ready = 1'b0;
      else if (rnd_ready)  bus.out_ready = ($urandom_range(0, 3) != 0);
      else                 bus.out_ready = 1'b1;
    end
  end

  // Monitor: compares every presented output against the scoreboard head.
  initial begin
    exp_t e;
    bit   seen;
    bit   post_hs;
    seen    = 1'b0;
    post_hs = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen    = 1'b0;
        post_hs = 1'b0;
        continue;
      end
      if (post_hs) begin
        check("idle_after_handshake", int'(bus.req_ready), 1);
        check("valid_dropped", int'(bus.out_valid), 0);
        post_hs = 1'b0;
      end
      if (bus.out_valid) begin
        check("req_ready_in_hold", int'(bus.req_ready), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          e = exp_q[0];
          if (!seen) begin
            seen = 1'b1;
            check("latency_cycle", cyc, e.rdy_cyc);
          end
          check("value", int'(bus.value), int'(e.v));
          check("tries", int'(bus.tries), e.k);
          if (e.lim != 0) check("in_range", int'(bus.value < 16'(e.lim)), 1);
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            n_done++;
            seen    = 1'b0;
            post_hs = 1'b1;
            $display("txn %0d lim=%0d value=%0d tries=%0d", n_done, e.lim, bus.value, bus.tries);
          end
        end
      end
    end
  end

  initial begin
    int lim;
    bus.req_valid = 1'b0;
    bus.limit     = 16'd0;
    bus.randnum   = 16'd0;
    #3;
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_value", int'(bus.value), 0);
    check("reset_tries", int'(bus.tries), 0);
    check("reset_req_ready", int'(bus.req_ready), 1);
    #19;
    rst = 1'b0;
    @(posedge clk);
    #1;

    set_seq(16'h1234, 16'h1234, 16'h1234); do_req(10, 1'b1, 0, 0);
    set_seq(16'h000F, 16'h000B, 16'h0007); do_req(10, 1'b1, 0, 0);
    set_seq(16'h000E, 16'h000E, 16'h000E); do_req(10, 1'b1, 0, 0);
    set_seq(16'hBEEF, 16'h0000, 16'h0000); do_req(0, 1'b1, 0, 0);
    set_seq(16'hFFFF, 16'hFFFF, 16'hFFFF); do_req(1, 1'b1, 0, 0);
    set_seq(16'h0010, 16'h0010, 16'h0010); do_req(17, 1'b1, 0, 0);
    set_seq(16'h001F, 16'h0003, 16'h0003); do_req(16, 1'b1, 0, 0);

    // Backpressure with the limit input wandering while the result is held.
    set_seq(16'h1234, 16'h1234, 16'h1234); do_req(10, 1'b1, 7, 0);
    repeat (6) begin
      bus.limit = 16'($urandom);
      @(posedge clk);
      #1;
    end

    // Abandon a rejecting request with an asynchronous reset mid-search.
    set_seq(16'h000F, 16'h000F, 16'h000F); do_req(10, 1'b1, 0, 3);
    set_seq(16'h0007, 16'h0007, 16'h0007); do_req(10, 1'b1, 0, 0);

    rnd_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 3))
        0:       lim = int'($urandom_range(0, 40));
        1:       lim = int'($urandom_range(0, 1)) << $urandom_range(0, 15);
        default: lim = int'($urandom_range(0, 65535));
      endcase
      do_req(lim, 1'b0, 0, 0);
    end
    rnd_ready = 1'b0;

    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    check("all_results_seen", n_done, n_issued);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rand_range.md
# rand_range

Downstream consumer of the 16-bit xorshift random generator. It samples the generator's free-running `randnum` word every clock and, on request, returns a value uniformly distributed in `[0, limit)`. It uses mask-and-reject sampling with a bounded retry count and a subtract fallback, so no divider is needed. Game/stimulus logic sees one registered result per request, with valid/ready handshakes on both sides.

## Interface
- `MAX_TRIES`, default 8: sampling attempts before fallback; legal range 1..15.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `randnum`  in  16  generator output; it advances every clock and is sampled as-is.
- `req_valid`  in  1  a request is present.
- `req_ready`  out  1  block can accept a request; high only in IDLE.
- `limit`  in  16  exclusive upper bound. 0 means the full 65536 range. Captured on the request handshake.
- `out_valid`  out  1  `value` is valid.
- `out_ready`  in  1  consumer accepts `value`.
- `value`  out  16  result; always less than the captured limit (unless limit = 0).
- `tries`  out  4  attempts used for the current or last result; read-only debug/verification port.

## Operation
- States: IDLE, SEARCH, HOLD. Only one request is outstanding at a time.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid && req_ready`: register `lim` = `limit` and `mask`, clear `tries`, go to SEARCH.
- Mask computation:
  - lim = 0 → `mask` = 0xFFFF.
  - lim = 1 → `mask` = 0.
  - Otherwise, with L = lim − 1: `mask` has ones at and below the MSB of L (e.g. lim = 10 → 0x000F; lim = 16 → 0x000F; lim = 17 → 0x001F).
- SEARCH, each cycle:
  - `cand` = `randnum & mask`; `tries` increments (saturating at 15).
  - Accept if lim = 0 or `cand` < lim.
  - If rejected on attempt number MAX_TRIES, use the fallback `cand − lim` instead. It is always < lim because `mask + 1` ≤ 2·(lim − 1) + 1.
  - On accept or fallback: register `value`, set `out_valid`, go to HOLD. Otherwise stay in SEARCH.
- HOLD:
  - `value` and `tries` are held stable while `out_valid && !out_ready`.
  - On `out_valid && out_ready`: clear `out_valid`, go to IDLE.
  - `req_ready` stays 0 until the cycle after the output handshake.
- Arithmetic: unsigned 16-bit. The comparison and the subtraction use the registered `lim`, never the live `limit` input.
- Changes on `limit` outside the request handshake cycle have no effect.

## Timing
- Reset (asynchronous, immediate): state = IDLE, `out_valid` = 0, `value` = 0, `tries` = 0, `req_ready` = 1.
- Reset mid-SEARCH or mid-HOLD abandons the request; no result is produced.
- Request handshake at edge N: SEARCH samples `randnum` during the cycle after edge N.
  - Earliest `out_valid` high is after edge N+1 (latency 2 edges from the handshake).
  - Worst case is MAX_TRIES + 1 edges.
- `req_ready` is a pure function of state (IDLE). `out_valid` and `value` are registered.
- `out_ready` asserted early, or held high continuously, is legal.
  - Back-to-back requests: the minimum period is 3 cycles (IDLE, SEARCH, HOLD).
- `req_valid` asserted in SEARCH or HOLD is ignored; the requester holds it until `req_ready`.

## Test plan
- Basic accept: limit = 10, `randnum` = 0x1234 in the first SEARCH cycle → `out_valid` after edge N+1, `value` = 4, `tries` = 1.
- Rejections: limit = 10, `randnum` sequence 0x000F, 0x000B, 0x0007 → `value` = 7, `tries` = 3, `out_valid` after the 3rd SEARCH edge.
- Fallback: MAX_TRIES = 8, limit = 10, `randnum` held at 0x000E → 8 rejections, then `value` = 4, `tries` = 8.
- Limit edge cases:
  - limit = 0 with `randnum` = 0xBEEF → `value` = 0xBEEF.
  - limit = 1 → `value` = 0, `tries` = 1.
  - limit = 17 with `randnum` = 0x0010 → `value` = 16.
- Backpressure: hold `out_ready` low for 5 cycles with `limit` changing → `value` and `tries` stable, `req_ready` = 0 throughout. `out_ready` high → IDLE next cycle.
- Reset mid-SEARCH: assert `rst` asynchronously between edges while rejecting → `out_valid` = 0 and `req_ready` = 1 immediately. After release, the next request completes normally. Also run 1000 requests against a live xorshift generator, checking `value` < `limit` every time.
